// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoded stage info into the hazard controller, pipeline-register controls out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_rs1_re;
    logic             id_rs2_re;
    logic [6:0]       ex_opcode;
    logic             ex_rd_we;
    logic [4:0]       ex_rd_addr;
    logic             ex_branch_taken;
    logic [6:0]       mem_opcode;
    logic             mem_ready;
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             bubble_mem_wb;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re, ex_opcode, ex_rd_we,
               ex_rd_addr, ex_branch_taken, mem_opcode, mem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, bubble_mem_wb, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_re, id_rs2_re, ex_opcode, ex_rd_we,
               ex_rd_addr, ex_branch_taken, mem_opcode, mem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, bubble_mem_wb, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline (load-use, redirect,
// data-memory wait with timeout watchdog) plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam int         WW    = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             abort_q, abort_d;
    logic [6:0]       abort_op_q, abort_op_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_access, load_use, timeout, abort_hold, mem_stall;
    logic             stall_all, redirect, interlock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            abort_op_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            abort_q     <= abort_d;
            abort_op_q  <= abort_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // An aborted access keeps its stall suppressed until a different opcode reaches MEM.
    always_comb begin
        mem_access  = bus.mem_opcode == LOAD || bus.mem_opcode == STORE;
        load_use    = bus.ex_opcode == LOAD && bus.ex_rd_we && bus.ex_rd_addr != 5'd0 &&
                      ((bus.id_rs1_re && bus.id_rs1_addr == bus.ex_rd_addr) ||
                       (bus.id_rs2_re && bus.id_rs2_addr == bus.ex_rd_addr));
        timeout     = state_q == MEM_WAIT && !bus.mem_ready && wait_cnt_q == WW'(MEM_TIMEOUT);
        abort_hold  = abort_q && bus.mem_opcode == abort_op_q;
        mem_stall   = mem_access && !bus.mem_ready && !timeout && !abort_hold;
        stall_all   = !rst && mem_stall;
        redirect    = !rst && !mem_stall && bus.ex_branch_taken;
        interlock   = !rst && !mem_stall && !bus.ex_branch_taken && load_use;
        state_d     = mem_stall ? MEM_WAIT : RUN;
        wait_cnt_d  = mem_stall ? wait_cnt_q + 1'b1 : '0;
        mem_err_d   = mem_err_q || timeout;
        abort_d     = abort_hold || timeout;
        abort_op_d  = timeout ? bus.mem_opcode : abort_op_q;
        stall_cnt_d = (stall_all || interlock) && stall_cnt_q != '1 ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    assign bus.stall_pc      = stall_all || interlock;
    assign bus.stall_if_id   = stall_all || interlock;
    assign bus.stall_id_ex   = stall_all;
    assign bus.stall_ex_mem  = stall_all;
    assign bus.flush_if_id   = redirect;
    assign bus.flush_id_ex   = redirect || interlock;
    assign bus.bubble_mem_wb = stall_all;
    assign bus.mem_err       = mem_err_q;
    assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard; a negedge monitor
// checks controls, the 32-bit counter and a 3-bit saturating twin.
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;
    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, bubble_mem_wb, mem_err}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_0100;
    localparam logic [7:0] BR   = 8'b0000_1100;
    localparam logic [7:0] MS   = 8'b1111_0010;
    localparam logic [7:0] ERR  = 8'b0000_0001;

    typedef struct {
        string      name;
        logic [7:0] ctl;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) m();
    pipe_hazard_ctrl_if #(.CNT_W(3))  s();

    assign s.id_rs1_addr     = m.id_rs1_addr;
    assign s.id_rs2_addr     = m.id_rs2_addr;
    assign s.id_rs1_re       = m.id_rs1_re;
    assign s.id_rs2_re       = m.id_rs2_re;
    assign s.ex_opcode       = m.ex_opcode;
    assign s.ex_rd_we        = m.ex_rd_we;
    assign s.ex_rd_addr      = m.ex_rd_addr;
    assign s.ex_branch_taken = m.ex_branch_taken;
    assign s.mem_opcode      = m.mem_opcode;
    assign s.mem_ready       = m.mem_ready;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(m));
    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_sat (.clk(clk), .rst(rst), .bus(s));

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] act;
        int         sat;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {m.stall_pc, m.stall_if_id, m.stall_id_ex, m.stall_ex_mem,
                   m.flush_if_id, m.flush_id_ex, m.bubble_mem_wb, m.mem_err};
            sat = e.cnt > 7 ? 7 : e.cnt;
            n_cmp++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
            end
            n_cmp++;
            if (m.stall_cnt !== 32'(e.cnt)) begin
                n_bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, m.stall_cnt, e.cnt);
            end
            n_cmp++;
            if (s.stall_cnt !== 3'(sat)) begin
                n_bad++;
                $display("FAIL %s sat_cnt: got %0d want %0d", e.name, s.stall_cnt, sat);
            end
        end
    end

    task automatic cyc(input string n, input logic [7:0] c, input int k);
        exp_t e;
        e.name = n;
        e.ctl  = c;
        e.cnt  = k;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m.id_rs1_addr     = 5'd0;
        m.id_rs2_addr     = 5'd0;
        m.id_rs1_re       = 1'b0;
        m.id_rs2_re       = 1'b0;
        m.ex_opcode       = 7'd0;
        m.ex_rd_we        = 1'b0;
        m.ex_rd_addr      = 5'd0;
        m.ex_branch_taken = 1'b0;
        m.mem_opcode      = 7'd0;
        m.mem_ready       = 1'b0;
    endtask

    task automatic lu(input logic [4:0] rd);
        idle();
        m.ex_opcode   = LOAD;
        m.ex_rd_we    = 1'b1;
        m.ex_rd_addr  = rd;
        m.id_rs2_re   = 1'b1;
        m.id_rs2_addr = 5'd5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        cyc("reset", NONE, 0);
        rst = 1'b0;
        lu(5'd5);                       cyc("load_use", LU, 0);
        idle();                         cyc("lu_release", NONE, 1);
        lu(5'd0); m.id_rs2_addr = 5'd0; cyc("lu_x0", NONE, 1);
        lu(5'd5); m.id_rs2_re = 1'b0;   cyc("lu_no_re", NONE, 1);
        idle();
        m.ex_opcode = LOAD; m.ex_rd_we = 1'b1; m.ex_rd_addr = 5'd7;
        m.id_rs1_re = 1'b1; m.id_rs1_addr = 5'd7;
        cyc("lu_rs1", LU, 1);
        lu(5'd5); m.ex_opcode = ALU;    cyc("alu_no_lu", NONE, 2);
        lu(5'd5); m.ex_branch_taken = 1'b1;
        cyc("branch_over_lu", BR, 2);
        idle();                         cyc("br_release", NONE, 2);
        m.mem_opcode = STORE;
        cyc("mw1", MS, 2);
        cyc("mw2", MS, 3);
        cyc("mw3", MS, 4);
        m.mem_ready = 1'b1;             cyc("mw_done", NONE, 5);
        idle();                         cyc("mw_idle", NONE, 5);
        m.mem_opcode = LOAD; m.ex_branch_taken = 1'b1;
        cyc("wb1", MS, 5);
        cyc("wb2", MS, 6);
        m.mem_ready = 1'b1;             cyc("wb_release", BR, 7);
        idle();                         cyc("wb_idle", NONE, 7);
        m.mem_opcode = LOAD;
        for (int i = 0; i < 4; i++) cyc("to_wait", MS, 7 + i);
        cyc("to_abort", NONE, 11);
        cyc("abort_hold1", ERR, 11);
        cyc("abort_hold2", ERR, 11);
        m.mem_opcode = 7'd0;            cyc("abort_clear", ERR, 11);
        m.mem_opcode = STORE; m.mem_ready = 1'b1;
        cyc("single_cycle", ERR, 11);
        lu(5'd5);                       cyc("lu_after_err", LU | ERR, 11);
        idle(); m.mem_opcode = LOAD;    cyc("rm1", MS | ERR, 12);
        cyc("rm2", MS | ERR, 13);
        rst = 1'b1;                     cyc("rst_mid", NONE, 0);
        idle(); rst = 1'b0;             cyc("post_rst", NONE, 0);
        m.mem_opcode = LOAD;            cyc("rst_restall", MS, 0);
        m.mem_ready = 1'b1;             cyc("rst_rerelease", NONE, 1);
        idle();                         cyc("pre_sat", NONE, 1);
        rst = 1'b1;                     cyc("sat_reset", NONE, 0);
        rst = 1'b0;
        lu(5'd5);
        for (int i = 0; i < 10; i++) cyc("sat", LU, i);
        idle();                         cyc("sat_end", NONE, 10);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage integer pipeline: generates per-register hold/bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Handles three hazard classes:
  - load-use interlock from EX;
  - taken-branch/jump redirect flush;
  - multi-cycle data-memory wait, with a timeout watchdog.
- Also keeps a saturating stall-cycle performance counter.
- Sits beside the pipeline registers; consumes decoded stage info, drives their enables.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before abort (≥2).
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs1_addr  in  5  rs1 of instruction in ID
- id_rs2_addr  in  5  rs2 of instruction in ID
- id_rs1_re  in  1  ID instruction reads rs1
- id_rs2_re  in  1  ID instruction reads rs2
- ex_opcode  in  7  opcode of instruction in EX
- ex_rd_we  in  1  EX instruction writes rd
- ex_rd_addr  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved taken branch/JAL/JALR (redirect this cycle)
- mem_opcode  in  7  opcode of instruction in MEM (EX_MEM output)
- mem_ready  in  1  data memory completes access this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF_ID
- stall_id_ex  out  1  hold ID_EX
- stall_ex_mem  out  1  hold EX_MEM
- flush_if_id  out  1  load bubble into IF_ID
- flush_id_ex  out  1  load bubble into ID_EX
- bubble_mem_wb  out  1  load bubble into MEM_WB
- mem_err  out  1  sticky: memory timeout occurred
- stall_cnt  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- Opcodes: LOAD = 7'b0000011, STORE = 7'b0100011; mem_access = mem_opcode is LOAD or STORE.
- Registered state: fsm {RUN, MEM_WAIT}, wait_cnt (clog2(MEM_TIMEOUT+1) bits), mem_err, stall_cnt.
- Outputs are combinational from state and current inputs (same-cycle response).
- Reset (async, rst=1): fsm=RUN, wait_cnt=0, mem_err=0, stall_cnt=0; all stall/flush/bubble outputs forced 0 while rst=1.
- Condition definitions:
  - load_use = ex_opcode==LOAD & ex_rd_we & ex_rd_addr!=0 & ((id_rs1_re & id_rs1_addr==ex_rd_addr) | (id_rs2_re & id_rs2_addr==ex_rd_addr)).
  - mem_stall = mem_access & !mem_ready, evaluated in both RUN and MEM_WAIT.
- Priority, highest first:
  1. mem_stall: stall_pc = stall_if_id = stall_id_ex = stall_ex_mem = 1, bubble_mem_wb = 1, flush_* = 0. Branch and load_use are ignored; they are re-evaluated when the stall releases because EX/ID are held.
  2. ex_branch_taken: flush_if_id = flush_id_ex = 1, no stalls. The redirect wins over load_use because the ID instruction is discarded.
  3. load_use: stall_pc = stall_if_id = 1, flush_id_ex = 1; EX_MEM/MEM_WB advance.
  4. Otherwise all controls 0.
- FSM:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt <= 1.
  - MEM_WAIT, mem_ready=1 -> RUN, wait_cnt <= 0. That cycle outputs are computed as in RUN (no mem stall), so the access completes and MEM_WB captures.
  - MEM_WAIT, mem_ready=0, wait_cnt < MEM_TIMEOUT: stay, wait_cnt+1.
  - MEM_WAIT, mem_ready=0, wait_cnt == MEM_TIMEOUT: mem_err <= 1, -> RUN. That cycle and subsequent cycles treat mem_stall as 0 until mem_opcode changes; the abort is tracked by an internal abort flag cleared when EX_MEM advances.
- A single-cycle access (mem_ready=1 on the first MEM cycle) never leaves RUN and costs no stall.
- mem_err is sticky until reset.
- stall_cnt increments every cycle stall_pc=1; it holds at all-ones (saturates, no wrap).
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared, no mem_err.

Test Plan:
- Load-use: ex_opcode=LOAD, ex_rd_we=1, ex_rd_addr=5, id_rs2_re=1, id_rs2_addr=5 -> stall_pc = stall_if_id = flush_id_ex = 1 for exactly 1 cycle. Repeat with ex_rd_addr=0 -> no stall. Repeat with id_rs2_re=0 -> no stall.
- Branch over load-use: same load-use inputs plus ex_branch_taken=1 -> flush_if_id = flush_id_ex = 1, stall_pc = 0.
- Memory wait: mem_opcode=STORE, mem_ready low 3 cycles then high -> all four stalls and bubble_mem_wb high for 3 cycles; fsm returns to RUN on the 4th cycle; stall_cnt = 3.
- Wait dominates branch: mem_stall active with ex_branch_taken=1 -> no flush until mem_ready; the flush then appears on the release cycle if the branch is still held.
- Timeout: MEM_TIMEOUT=4, mem_opcode=LOAD, mem_ready=0 indefinitely -> mem_err rises after cycle 5 of the access; stalls drop and the pipeline advances; mem_err stays 1.
- Reset/saturation: assert rst mid-MEM_WAIT -> all outputs 0 immediately, stall_cnt=0. With CNT_W=3 and a 10-cycle stall -> stall_cnt = 7.
